// File: rtl/blinky_array_pkg.sv
// Shared types and helpers for the blinky_array LED driver.
package blinky_array_pkg;

    // Per-channel operating mode, encoded exactly as driven on i_mode.
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_e;

    // Width of one channel's rate-select field; never narrower than one bit.
    function automatic int calc_rate_w(input int num_rates);
        return (num_rates <= 1) ? 1 : $clog2(num_rates);
    endfunction

endpackage

// File: rtl/blinky_channel.sv
// One LED channel: rate selection, burst sequencing and the registered LED drive.
module blinky_channel
    import blinky_array_pkg::*;
#(
    parameter int   NUM_RATES = 4,
    parameter int   RATE_W    = 2,
    parameter int   BURST_LEN = 3,
    parameter int   BURST_GAP = 2,
    parameter logic POLARITY  = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sync,
    input  logic [NUM_RATES-1:0] phase,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [RATE_W-1:0]    rate,
    output logic                 led
);

    localparam int                CNT_W    = $clog2(BURST_LEN + BURST_GAP);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(BURST_LEN + BURST_GAP - 1);
    localparam logic [CNT_W-1:0]  CNT_LEN  = CNT_W'(BURST_LEN);
    localparam logic [RATE_W-1:0] RATE_TOP = RATE_W'(NUM_RATES - 1);

    mode_e             mode_in;
    mode_e             mode_q;
    logic [RATE_W-1:0] rate_q;
    logic [RATE_W-1:0] rate_sel;
    logic              sel_bit;
    logic              sel_bit_q;
    logic              rise;
    logic              changed;
    logic [CNT_W-1:0]  burst_cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              raw;

    // Select the phase bit, detect its rising edge and work out the next burst count and raw LED value.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        mode_in  = mode_e'(mode);
        rate_sel = (int'(rate) >= NUM_RATES) ? RATE_TOP : rate;
        sel_bit  = phase[rate_sel];
        rise     = sel_bit & ~sel_bit_q;
        changed  = (mode_in != mode_q) || (rate != rate_q);
        cnt_next = burst_cnt;
        raw      = 1'b0;

        // A restart parks the counter at its last value so the next edge wraps it to 0 and opens a burst.
        if (sync || changed) begin
            cnt_next = CNT_MAX;
        end else if (rise) begin
            cnt_next = (burst_cnt == CNT_MAX) ? '0 : burst_cnt + 1'b1;
        end

        case (mode_in)
            MODE_ON:    raw = 1'b1;
            MODE_BLINK: raw = sel_bit;
            MODE_BURST: raw = sel_bit & (cnt_next < CNT_LEN);
            default:    raw = 1'b0;
        endcase
    end

    // Channel state: configuration copies, edge history, burst count and the gated, polarity-adjusted LED.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q    <= MODE_OFF;
            rate_q    <= '0;
            sel_bit_q <= 1'b0;
            burst_cnt <= CNT_MAX;
            led       <= POLARITY;
        end else begin
            mode_q    <= mode_in;
            rate_q    <= rate;
            sel_bit_q <= sel_bit;
            burst_cnt <= cnt_next;
            led       <= (raw & enable) ^ POLARITY;
        end
    end

endmodule

// File: rtl/blinky_array.sv
// Multi-channel LED blinker: shared prescaler and phase counter feeding NUM_CH independent channels.
module blinky_array
    import blinky_array_pkg::*;
#(
    parameter int                NUM_CH    = 4,
    parameter int                NUM_RATES = 4,
    parameter int                BASE_HALF = 1250,
    parameter int                BURST_LEN = 3,
    parameter int                BURST_GAP = 2,
    parameter logic [NUM_CH-1:0] POLARITY  = '0,
    localparam int               RATE_W    = calc_rate_w(NUM_RATES)
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_sync,
    input  logic [NUM_CH-1:0]        i_enable,
    input  logic [2*NUM_CH-1:0]      i_mode,
    input  logic [RATE_W*NUM_CH-1:0] i_rate,
    output logic [NUM_CH-1:0]        o_led
);

    localparam int               PRE_W    = $clog2(BASE_HALF);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BASE_HALF - 1);

    logic [PRE_W-1:0]     prescale;
    logic                 tick;
    logic [NUM_RATES-1:0] phase;

    assign tick = (prescale == PRE_LAST);

    // Shared timebase: prescaler produces one tick per half-period of rate 0; sync restarts both counters.
    always_ff @(posedge i_clock or posedge i_reset) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (i_reset) begin
            prescale <= '0;
            phase    <= '0;
        end else if (i_sync) begin
            prescale <= '0;
            phase    <= '0;
        end else begin
            prescale <= tick ? '0 : prescale + 1'b1;
            if (tick) begin
                phase <= phase + 1'b1;
            end
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        blinky_channel #(
            .NUM_RATES (NUM_RATES),
            .RATE_W    (RATE_W),
            .BURST_LEN (BURST_LEN),
            .BURST_GAP (BURST_GAP),
            .POLARITY  (POLARITY[ch])
        ) u_channel (
            .clock  (i_clock),
            .reset  (i_reset),
            .sync   (i_sync),
            .phase  (phase),
            .enable (i_enable[ch]),
            .mode   (i_mode[2*ch +: 2]),
            .rate   (i_rate[RATE_W*ch +: RATE_W]),
            .led    (o_led[ch])
        );
    end

endmodule

// File: tb/tb_blinky_array.sv
// Directed bench for blinky_array: reset, blink, burst, gating, clamping, ON, sync and mode change.
module tb_blinky_array;
    import blinky_array_pkg::*;

    logic       i_clock  = 1'b0;
    logic       i_reset  = 1'b0;
    logic       i_sync   = 1'b0;
    logic [1:0] i_enable = 2'b11;
    logic [3:0] i_mode   = '0;
    logic [3:0] i_rate   = '0;
    logic [1:0] o_led;

    int n_compared   = 0;
    int n_mismatched = 0;
    int edge_n       = 0;

    blinky_array #(
        .NUM_CH    (2),
        .NUM_RATES (3),
        .BASE_HALF (4),
        .BURST_LEN (2),
        .BURST_GAP (1),
        .POLARITY  (2'b10)
    ) dut (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_sync   (i_sync),
        .i_enable (i_enable),
        .i_mode   (i_mode),
        .i_rate   (i_rate),
        .o_led    (o_led)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge i_clock);
        #1;
        edge_n++;
    endtask

    // Rate-0 blink after a phase restart: low for edges 1..4, high 5..8, period 8.
    function automatic int blink0(input int n);
        return ((n - 1) / 4) % 2;
    endfunction

    // Rate-0 burst: pulses follow the blink waveform from edge 'first', two on and one silent per 24 edges.
    function automatic int burst0(input int n, input int first);
        if (n < first) return 0;
        if (blink0(n) == 0) return 0;
        return ((((n - first) / 8) % 3) != 2) ? 1 : 0;
    endfunction

    initial begin
        int s_edge;
        int k;

        // Reset applied with no clock edge yet.
        i_mode = {MODE_OFF, MODE_BLINK};
        #2 i_reset = 1'b1;
        #1 check("reset_init", o_led, 2'b10);
        step();
        step();
        i_reset = 1'b0;
        edge_n  = 0;

        // Run into the first high half of ch0, then assert reset between edges.
        repeat (6) step();
        check("pre_reset_high", o_led, 2'b11);
        #3 i_reset = 1'b1;
        #1 check("async_reset", o_led, 2'b10);
        step();
        check("reset_held", o_led, 2'b10);
        i_reset = 1'b0;
        edge_n  = 0;

        // Blink rate 0 from release.
        repeat (24) begin
            step();
            check($sformatf("blink0_e%0d", edge_n), o_led[0], blink0(edge_n));
        end
        check("off_pol1", o_led[1], 1);

        // Enable dropped for edges 30 and 31 (high half 29..32); phase must carry on.
        repeat (24) begin
            i_enable[0] = (edge_n + 1 == 30 || edge_n + 1 == 31) ? 1'b0 : 1'b1;
            step();
            check($sformatf("gate_e%0d", edge_n), o_led[0],
                  (edge_n == 30 || edge_n == 31) ? 0 : blink0(edge_n));
        end
        i_enable[0] = 1'b1;

        // Burst on ch0 and clamped rate 3 blink on ch1, from a fresh reset.
        i_mode  = {MODE_BLINK, MODE_BURST};
        i_rate  = {2'd3, 2'd0};
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        edge_n  = 0;
        repeat (64) begin
            step();
            check($sformatf("burst_e%0d", edge_n), o_led[0], burst0(edge_n, 5));
            check($sformatf("clamp_e%0d", edge_n), o_led[1], (((edge_n - 1) / 16) % 2 == 1) ? 0 : 1);
        end

        // ON with inverted polarity holds the pin low.
        i_mode[3:2] = MODE_ON;
        repeat (8) begin
            step();
            check($sformatf("on_e%0d", edge_n), o_led[1], 0);
        end

        // Sync landing on a tick edge: timing must match post-reset.
        i_mode[1:0] = MODE_BLINK;
        for (int i = 0; i < 4 && (edge_n % 4) != 3; i++) step();
        check("sync_align", edge_n % 4, 3);
        i_sync = 1'b1;
        step();
        i_sync = 1'b0;
        s_edge = edge_n;
        for (int j = 1; j <= 17; j++) begin
            step();
            k = edge_n - s_edge;
            check($sformatf("sync_k%0d", k), o_led[0], blink0(k));
        end

        // BLINK -> BURST in the low half: burst restarts at the next rise (k=21).
        i_mode[1:0] = MODE_BURST;
        for (int j = 18; j <= 48; j++) begin
            step();
            k = edge_n - s_edge;
            check($sformatf("modechg_k%0d", k), o_led[0], burst0(k, 21));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/blinky_array.md
BLINKY_ARRAY -- requirements
Module: blinky_array

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of independent LED channels (at least 1).
REQ-002 The block SHALL have parameter NUM_RATES, default 4, meaning the number of selectable blink rates (at least 1); RATE_W = max(1, clog2(NUM_RATES)).
REQ-003 The block SHALL have parameter BASE_HALF, default 1250, meaning the clock count per half-period of rate 0 (at least 2).
REQ-004 The block SHALL have parameter BURST_LEN, default 3, meaning the number of high pulses per burst (at least 1).
REQ-005 The block SHALL have parameter BURST_GAP, default 2, meaning the number of silent rate periods after each burst (at least 1).
REQ-006 The block SHALL have parameter POLARITY, width NUM_CH, default 0; bit i = 1 inverts o_led[i].
REQ-007 The block SHALL have port i_clock, input, width 1: the single clock, rising-edge active.
REQ-008 The block SHALL have port i_reset, input, width 1: reset, asynchronous, active-high.
REQ-009 The block SHALL have port i_sync, input, width 1: synchronous phase restart, one-cycle pulse.
REQ-010 The block SHALL have port i_enable, input, width NUM_CH: per-channel output enable.
REQ-011 The block SHALL have port i_mode, input, width 2*NUM_CH: per-channel mode (0 OFF, 1 ON, 2 BLINK, 3 BURST).
REQ-012 The block SHALL have port i_rate, input, width RATE_W*NUM_CH: per-channel rate select.
REQ-013 The block SHALL have port o_led, output, width NUM_CH: registered LED drive.

Function
REQ-014 The prescaler SHALL count 0..BASE_HALF-1, assert tick on the cycle it equals BASE_HALF-1, and wrap to 0.
REQ-015 The phase counter SHALL be NUM_RATES bits, increment on tick, and wrap at all-ones; rate k is phase bit k, so rate k has a period of 2^(k+1)*BASE_HALF clocks at 50% duty.
REQ-016 An i_rate value of NUM_RATES or greater SHALL be clamped to NUM_RATES-1.
REQ-017 The channel's raw LED value SHALL be: OFF -> 0; ON -> 1; BLINK -> the selected phase bit; BURST -> the selected phase bit AND burst count < BURST_LEN.
REQ-018 The burst counter SHALL hold values 0..BURST_LEN+BURST_GAP-1, advance on each 0->1 transition of the selected phase bit, and wrap to 0 after the maximum; the raw value SHALL use the post-advance count.
REQ-019 o_led[i] SHALL equal (raw AND i_enable[i]) XOR POLARITY[i], registered with 1-cycle latency from inputs and phase.
REQ-020 While i_enable[i]=0, the prescaler, phase counter and burst counter SHALL keep running; only the output is gated.
REQ-021 A change of i_mode or i_rate on a channel (compared with its registered copy) SHALL update the copy and load the burst counter with BURST_LEN+BURST_GAP-1, so the next edge starts a fresh burst.
REQ-022 i_sync SHALL clear the prescaler and phase counter and load every burst counter with BURST_LEN+BURST_GAP-1; if i_sync coincides with a tick, i_sync SHALL win (no increment).

Reset
REQ-023 While i_reset is high, the prescaler and phase counter SHALL be 0, burst counters SHALL be BURST_LEN+BURST_GAP-1, mode/rate copies SHALL be OFF/0, and o_led SHALL be POLARITY.
REQ-024 Reset assertion SHALL take effect immediately, without waiting for a clock edge; counting SHALL resume on the first i_clock edge after release.

Structure
REQ-025 A shared package SHALL hold the mode enum (OFF, ON, BLINK, BURST) and the RATE_W derivation function.
REQ-026 The per-channel logic SHALL be the sub-module blinky_channel, instantiated NUM_CH times; the prescaler and phase counter SHALL be shared in the top level.

Verification (NUM_CH=2, NUM_RATES=3, BASE_HALF=4, BURST_LEN=2, BURST_GAP=1, POLARITY=2'b10)
REQ-027 The bench SHALL check reset: assert i_reset mid-run -> o_led=2'b10 with no clock edge; after release ch0 BLINK rate 0 -> first o_led[0] rise at clock edge 5, then 4 high / 4 low, period 8.
REQ-028 The bench SHALL check BURST: ch0 BURST rate 0 -> two 4-clock high pulses, then 12 clocks low, repeating every 24 clocks.
REQ-029 The bench SHALL check enable gating: i_enable[0]=0 for 2 cycles mid-high -> o_led[0] low for exactly 2 cycles, delayed by 1 cycle; phase after re-enable is unchanged from the undisturbed waveform.
REQ-030 The bench SHALL check clamping and ON mode: ch1 BLINK i_rate=3 -> period 32 (same as rate 2); ch1 ON with POLARITY[1]=1 -> o_led[1] constant 0.
REQ-031 The bench SHALL check sync: i_sync coinciding with a tick -> phase=0; the next o_led[0] rise occurs 5 edges after the sync edge, identical to post-reset timing.
REQ-032 The bench SHALL check mode change: BLINK->BURST mid-period -> burst restarts, so the next two rising edges give full pulses followed by the gap.
